mdioconf_hst_resp: RTL and testbench
====================================

Name: mdioconf_hst_resp

Overview:
- Responder end of the MAC host configuration interface: accepts host_opcode/host_addr/host_wr_data/host_miim_sel/host_req and answers with host_rd_data/host_miim_rdy.
- Holds the MAC configuration word registers and runs a Clause-45 MDIO master (MDC/MDIO) for MIIM accesses.
- Used as the host-interface target in the MAC wrapper and as the bench model for the configuration FSM.

Parameters:
- PREAMBLE_BITS, 32, number of '1' preamble bits sent before each MDIO frame.
- MIN_HALF_PERIOD, 2, lower clamp in host_clk cycles on the MDC half-period.

Ports:
- host_clk  in  1  the block's single clock.
- host_reset  in  1  asynchronous reset, active-high.
- host_opcode  in  2  config path: bit1=0 write, 2'b11 read/idle. MIIM path: 00 address, 01 write, 11 read, 10 read-increment.
- host_addr  in  10  config: register address. MIIM: [9:5] PRTAD, [4:0] DEVAD.
- host_wr_data  in  32  config write data; MIIM uses [15:0].
- host_rd_data  out  32  config read data or MIIM read data in [15:0].
- host_miim_sel  in  1  0 selects the config path, 1 selects the MIIM path.
- host_req  in  1  one-cycle MIIM request strobe.
- host_miim_rdy  out  1  MIIM engine idle and able to accept a request.
- cfg_rx_word1  out  32  contents of register 0x240.
- cfg_tx_word  out  32  contents of register 0x280.
- mdc  out  1  MDIO clock.
- mdio_o  out  1  MDIO output data.
- mdio_t  out  1  MDIO tristate control; 1 = high-Z.
- mdio_i  in  1  MDIO input data.

Behaviour:
- Reset (asynchronous):
  - Registers 0x240, 0x280 and 0x340 cleared to 0.
  - host_rd_data=0, host_miim_rdy=0, mdc=0, mdio_o=1, mdio_t=1.
  - FSM returns to IDLE; any frame in progress is abandoned with no further MDC edges.
- Config path (host_miim_sel=0; host_req is ignored):
  - Write: if host_opcode[1]=0, host_wr_data is written to the register addressed by host_addr in that cycle. Unmapped addresses are dropped.
  - Read: if host_opcode=2'b11, host_rd_data equals the addressed register one cycle later. Unmapped addresses read 0.
- Management word 0x340:
  - [4:0] clk_div. MDC half-period = max(clk_div+1, MIN_HALF_PERIOD) host_clk cycles.
  - [5] mdio_en.
  - clk_div is sampled only at frame start; a change mid-frame takes effect on the next frame.
- host_miim_rdy = 1 only when the FSM is in IDLE and mdio_en=1.
- MIIM FSM:
  - IDLE: on host_req && host_miim_sel && host_miim_rdy, latch opcode, addr and wr_data[15:0]. host_miim_rdy drops the next cycle. Go to PRE.
  - host_req while not ready is ignored, not queued.
  - Frame = PRE(PREAMBLE_BITS ones) → ST(00) → OP(2) → PRTAD(5) → DEVAD(5) → TA(2) → DATA(16), sent MSB first.
  - mdio_o/mdio_t change only on MDC falling edges; mdio_i is sampled on MDC rising edges.
  - Address/write frames: TA=10, DATA=latched wr_data, mdio_t=0 from PRE through DATA.
  - Read/read-increment frames: mdio_t=1 during TA and DATA; 16 bits are shifted in from mdio_i.
  - DONE: after the last data bit's rising edge plus one half-period, return mdc=0, mdio_t=1, mdio_o=1.
  - For reads, host_rd_data[15:0] (upper bits 0) is updated in the same cycle host_miim_rdy reasserts, and holds until the next completed read or config read.
  - Next frame may start the cycle after host_miim_rdy reasserts.
- Frame length (PREAMBLE_BITS=32): 64 MDC periods. With clk_div=9, latency from the accepted request to host_miim_rdy=1 is 64*20 + 1 host_clk cycles (±1).
- Clearing mdio_en mid-frame: the frame still completes; host_miim_rdy stays 0 afterwards.
- Config-path accesses while a frame is in flight are serviced normally. They do not disturb the frame, except that host_rd_data is overwritten by a config read.

Test Plan:
- Config write 0x340 ← 0x0000_0029, then read 0x340 → host_rd_data=0x29 one cycle later. host_miim_rdy rises the cycle after the write. A read of 0x300 returns 0.
- Write 0x240 ← 0x1C00_0000 → cfg_rx_word1=0x1C00_0000. Write 0x280 ← 0x1100_0000 → cfg_tx_word=0x1100_0000.
- mdio_en=1, clk_div=9; MIIM write opcode 01, addr 0x021, data 0xA5A5:
  - bench MDIO monitor captures 32 ones, 00, 01, 00001, 00001, 10, 0xA5A5;
  - MDC period is 20 cycles;
  - host_miim_rdy returns after about 1281 cycles.
- MIIM read opcode 11, with the PHY model driving 0xBEEF → mdio_t=1 during TA/DATA, host_rd_data=0x0000_BEEF when host_miim_rdy rises.
- Second host_req pulse mid-frame → ignored, exactly one frame seen on MDIO. host_req with mdio_en=0 → no MDC activity, host_miim_rdy stays 0.
- Assert host_reset mid-DATA → mdc=0, mdio_t=1 and host_miim_rdy=0 immediately. After release, the 0x340 rewrite plus a new request produce a complete, clean frame.

Source files
------------

// File: rtl/mdioconf_hst_resp.sv
// Host configuration responder: MAC configuration word registers plus a
// Clause-45 MDIO master serving MIIM requests from the same host interface.
module mdioconf_hst_resp #(
    parameter int PREAMBLE_BITS   = 32,
    parameter int MIN_HALF_PERIOD = 2
) (
    input  logic        host_clk,
    input  logic        host_reset,
    input  logic [1:0]  host_opcode,
    input  logic [9:0]  host_addr,
    input  logic [31:0] host_wr_data,
    output logic [31:0] host_rd_data,
    input  logic        host_miim_sel,
    input  logic        host_req,
    output logic        host_miim_rdy,
    output logic [31:0] cfg_rx_word1,
    output logic [31:0] cfg_tx_word,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic        mdio_i
);
    typedef enum logic [1:0] {IDLE, PRE, XFER, DONE} state_t;

    localparam logic [9:0] ADDR_RX1  = 10'h240;
    localparam logic [9:0] ADDR_TX   = 10'h280;
    localparam logic [9:0] ADDR_MGMT = 10'h340;
    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BITS - 1);
    localparam logic [5:0] MIN_M1    = 6'(MIN_HALF_PERIOD - 1);

    logic [31:0] rx1_reg;
    logic [31:0] tx_reg;
    logic [31:0] mgmt_reg;
    logic [31:0] rd_data_reg;
    logic [31:0] rd_mux;

    state_t      state_reg;
    logic [5:0]  half_m1_reg;
    logic [5:0]  half_cnt_reg;
    logic [7:0]  bit_cnt_reg;
    logic [31:0] tx_sh_reg;
    logic [15:0] rx_sh_reg;
    logic        is_read_reg;
    logic        mdc_reg;
    logic        mdio_o_reg;
    logic        mdio_t_reg;

    logic        cfg_wr;
    logic        cfg_rd;
    logic        start;
    logic [5:0]  div_m1;
    logic [5:0]  half_m1_next;
    logic [1:0]  ta_bits;
    logic [15:0] data_bits;

    assign cfg_wr = !host_miim_sel && !host_opcode[1];
    assign cfg_rd = !host_miim_sel && (host_opcode == 2'b11);

    assign host_miim_rdy = (state_reg == IDLE) && mgmt_reg[5];
    assign start         = host_req && host_miim_sel && host_miim_rdy;

    // Half-period minus one, so the down-counter reloads directly.
    assign div_m1       = {1'b0, mgmt_reg[4:0]};
    assign half_m1_next = (div_m1 >= MIN_M1) ? div_m1 : MIN_M1;

    // Reads release the line for TA/DATA, so the shifted-out bits there are don't-care.
    assign ta_bits   = host_opcode[1] ? 2'b11 : 2'b10;
    assign data_bits = host_opcode[1] ? 16'hFFFF : host_wr_data[15:0];

    always_comb begin
        rd_mux = 32'h0;
        case (host_addr)
            ADDR_RX1:  rd_mux = rx1_reg;
            ADDR_TX:   rd_mux = tx_reg;
            ADDR_MGMT: rd_mux = mgmt_reg;
            default:   rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge host_clk or posedge host_reset) begin
        if (host_reset) begin
            rx1_reg  <= 32'h0;
            tx_reg   <= 32'h0;
            mgmt_reg <= 32'h0;
        end else if (cfg_wr) begin
            case (host_addr)
                ADDR_RX1:  rx1_reg  <= host_wr_data;
                ADDR_TX:   tx_reg   <= host_wr_data;
                ADDR_MGMT: mgmt_reg <= host_wr_data;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge host_clk or posedge host_reset) begin
        if (host_reset) begin
            state_reg    <= IDLE;
            half_m1_reg  <= 6'h0;
            half_cnt_reg <= 6'h0;
            bit_cnt_reg  <= 8'h0;
            tx_sh_reg    <= 32'h0;
            rx_sh_reg    <= 16'h0;
            is_read_reg  <= 1'b0;
            mdc_reg      <= 1'b0;
            mdio_o_reg   <= 1'b1;
            mdio_t_reg   <= 1'b1;
            rd_data_reg  <= 32'h0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= PRE;
                        is_read_reg  <= host_opcode[1];
                        tx_sh_reg    <= {2'b00, host_opcode, host_addr, ta_bits, data_bits};
                        half_m1_reg  <= half_m1_next;
                        half_cnt_reg <= half_m1_next;
                        bit_cnt_reg  <= PRE_LAST;
                        mdc_reg      <= 1'b0;
                        mdio_o_reg   <= 1'b1;
                        mdio_t_reg   <= 1'b0;
                    end
                end
                default: begin
                    if (half_cnt_reg != 6'h0) begin
                        half_cnt_reg <= half_cnt_reg - 6'd1;
                    end else begin
                        half_cnt_reg <= half_m1_reg;
                        if (!mdc_reg) begin
                            // Rising edge: sample read data; last bit moves on to DONE.
                            mdc_reg <= 1'b1;
                            if (state_reg == XFER) begin
                                if (is_read_reg && (bit_cnt_reg <= 8'd15))
                                    rx_sh_reg <= {rx_sh_reg[14:0], mdio_i};
                                if (bit_cnt_reg == 8'd0)
                                    state_reg <= DONE;
                            end
                        end else begin
                            mdc_reg <= 1'b0;
                            if (state_reg == DONE) begin
                                state_reg  <= IDLE;
                                mdio_o_reg <= 1'b1;
                                mdio_t_reg <= 1'b1;
                                if (is_read_reg)
                                    rd_data_reg <= {16'h0, rx_sh_reg};
                            end else if ((state_reg == PRE) && (bit_cnt_reg == 8'd0)) begin
                                state_reg   <= XFER;
                                bit_cnt_reg <= 8'd31;
                                mdio_o_reg  <= tx_sh_reg[31];
                                tx_sh_reg   <= {tx_sh_reg[30:0], 1'b0};
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - 8'd1;
                                if (state_reg == XFER) begin
                                    mdio_o_reg <= tx_sh_reg[31];
                                    tx_sh_reg  <= {tx_sh_reg[30:0], 1'b0};
                                    // Next bit index <= 17 is TA or DATA.
                                    mdio_t_reg <= is_read_reg && (bit_cnt_reg <= 8'd18);
                                end
                            end
                        end
                    end
                end
            endcase
            // A config read in the same cycle takes precedence over MIIM read data.
            if (cfg_rd)
                rd_data_reg <= rd_mux;
        end
    end

    assign host_rd_data = rd_data_reg;
    assign cfg_rx_word1 = rx1_reg;
    assign cfg_tx_word  = tx_reg;
    assign mdc          = mdc_reg;
    assign mdio_o       = mdio_o_reg;
    assign mdio_t       = mdio_t_reg;

endmodule

// File: tb/tb_mdioconf_hst_resp.sv
// Directed bench for mdioconf_hst_resp: config register vectors plus MDIO
// frame sequences observed through an MDC-edge monitor and a PHY read model.
module tb_mdioconf_hst_resp;
    logic        host_clk = 1'b0;
    logic        host_reset = 1'b1;
    logic [1:0]  host_opcode = 2'b11;
    logic [9:0]  host_addr = 10'h0;
    logic [31:0] host_wr_data = 32'h0;
    logic        host_miim_sel = 1'b0;
    logic        host_req = 1'b0;
    logic [31:0] host_rd_data, cfg_rx_word1, cfg_tx_word;
    logic        host_miim_rdy, mdc, mdio_o, mdio_t;
    logic        mdio_i = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int K_RD = 0, K_RX = 1, K_TX = 2, K_RDY = 3;

    typedef struct {
        logic [1:0]  op;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        req;
        int          kind;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    always #5 host_clk = ~host_clk;

    mdioconf_hst_resp dut (
        .host_clk      (host_clk),
        .host_reset    (host_reset),
        .host_opcode   (host_opcode),
        .host_addr     (host_addr),
        .host_wr_data  (host_wr_data),
        .host_rd_data  (host_rd_data),
        .host_miim_sel (host_miim_sel),
        .host_req      (host_req),
        .host_miim_rdy (host_miim_rdy),
        .cfg_rx_word1  (cfg_rx_word1),
        .cfg_tx_word   (cfg_tx_word),
        .mdc           (mdc),
        .mdio_o        (mdio_o),
        .mdio_t        (mdio_t),
        .mdio_i        (mdio_i)
    );

    // MDC-edge monitor: one record per rising edge.
    int   total = 0;
    int   cyc   = 0;
    int   base  = 0;
    logic [15:0] phy_word = 16'h0;
    logic bit_o [0:1023];
    logic bit_t [0:1023];
    int   rise_cyc [0:1023];

    always @(posedge host_clk) cyc <= cyc + 1;

    always @(posedge mdc) begin
        if (total < 1024) begin
            bit_o[total]    <= mdio_o;
            bit_t[total]    <= mdio_t;
            rise_cyc[total] <= cyc;
        end
        total <= total + 1;
    end

    // PHY model: presents read data after each falling edge, bit 48 onward.
    always @(negedge mdc) begin : phy
        int k;
        k = total - base;
        if (k >= 48 && k < 64) mdio_i <= phy_word[63 - k];
        else                   mdio_i <= 1'b1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, got);
        end
    endtask

    task automatic cfg_cycle(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] data);
        host_miim_sel = 1'b0; host_opcode = op; host_addr = addr; host_wr_data = data;
        @(negedge host_clk);
        host_miim_sel = 1'b1; host_opcode = 2'b11;
    endtask

    // inj: 0 none, 1 second req mid-frame, 2 clear mdio_en mid-frame, 3 config read mid-frame
    task automatic run_frame(input logic [1:0] op, input logic [9:0] addr, input logic [15:0] data,
                             input int inj, output int lat, output logic [63:0] fo,
                             output logic [63:0] ft, output int nbits);
        int   n;
        logic done;
        base = total;
        host_miim_sel = 1'b1; host_opcode = op; host_addr = addr;
        host_wr_data = {16'h0, data}; host_req = 1'b1;
        @(negedge host_clk);
        n = 1;
        check("rdy_drop_after_accept", host_miim_rdy, 1'b0);
        host_req = 1'b0;
        done = 1'b0;
        while (!done && n < 3000) begin
            if (inj == 1 && n == 300) host_req = 1'b1;
            if (inj == 1 && n == 301) host_req = 1'b0;
            if (inj == 2 && n == 200) begin
                host_miim_sel = 1'b0; host_opcode = 2'b00; host_addr = 10'h340; host_wr_data = 32'h09;
            end
            if (inj == 3 && n == 400) begin
                host_miim_sel = 1'b0; host_opcode = 2'b11; host_addr = 10'h240;
            end
            @(negedge host_clk);
            n++;
            if (inj == 3 && n == 401) check("cfg_read_mid_frame", host_rd_data, 32'h1C00_0000);
            if ((inj == 2 && n == 201) || (inj == 3 && n == 401)) begin
                host_miim_sel = 1'b1; host_opcode = 2'b11;
            end
            done = host_miim_rdy || (inj == 2 && (total - base) == 64 && mdio_t && !mdc);
        end
        check("frame_completed_in_bound", (n < 3000), 1'b1);
        lat   = n;
        nbits = total - base;
        fo = 64'h0; ft = 64'h0;
        for (int k = 0; k < 64; k++) begin
            if (base + k < 1024) begin
                fo[63 - k] = bit_o[base + k];
                ft[63 - k] = bit_t[base + k];
            end
        end
    endtask

    initial begin
        int          lat, nbits, b0, n;
        logic [63:0] fo, ft;

        vecs[0]  = '{2'b00, 10'h340, 32'h0000_0029, 1'b0, K_RDY, 32'h1};
        vecs[1]  = '{2'b11, 10'h340, 32'h0,         1'b0, K_RD,  32'h29};
        vecs[2]  = '{2'b11, 10'h300, 32'h0,         1'b0, K_RD,  32'h0};
        vecs[3]  = '{2'b00, 10'h240, 32'h1C00_0000, 1'b0, K_RX,  32'h1C00_0000};
        vecs[4]  = '{2'b00, 10'h280, 32'h1100_0000, 1'b0, K_TX,  32'h1100_0000};
        vecs[5]  = '{2'b11, 10'h240, 32'h0,         1'b0, K_RD,  32'h1C00_0000};
        vecs[6]  = '{2'b11, 10'h280, 32'h0,         1'b0, K_RD,  32'h1100_0000};
        vecs[7]  = '{2'b10, 10'h300, 32'hFFFF_FFFF, 1'b0, K_RX,  32'h1C00_0000};
        vecs[8]  = '{2'b01, 10'h280, 32'h1234_5678, 1'b0, K_TX,  32'h1234_5678};
        vecs[9]  = '{2'b11, 10'h300, 32'h0,         1'b0, K_RD,  32'h0};
        vecs[10] = '{2'b11, 10'h340, 32'h0,         1'b1, K_RDY, 32'h1};
        vecs[11] = '{2'b00, 10'h280, 32'h1100_0000, 1'b0, K_TX,  32'h1100_0000};

        // Reset state
        repeat (3) @(negedge host_clk);
        check("reset_rd_data", host_rd_data, 32'h0);
        check("reset_rdy", host_miim_rdy, 1'b0);
        check("reset_mdc_t_o", {mdc, mdio_t, mdio_o}, 3'b011);
        check("reset_cfg_words", {cfg_rx_word1, cfg_tx_word}, 64'h0);
        host_reset = 1'b0;
        @(negedge host_clk);

        // Config path table
        for (int i = 0; i < 12; i++) begin
            host_miim_sel = 1'b0;
            host_opcode   = vecs[i].op;
            host_addr     = vecs[i].addr;
            host_wr_data  = vecs[i].wdata;
            host_req      = vecs[i].req;
            @(negedge host_clk);
            case (vecs[i].kind)
                K_RD:    check($sformatf("vec%0d_rd_data", i), host_rd_data, vecs[i].exp);
                K_RX:    check($sformatf("vec%0d_cfg_rx_word1", i), cfg_rx_word1, vecs[i].exp);
                K_TX:    check($sformatf("vec%0d_cfg_tx_word", i), cfg_tx_word, vecs[i].exp);
                default: check($sformatf("vec%0d_rdy", i), host_miim_rdy, vecs[i].exp[0]);
            endcase
        end
        host_req = 1'b0; host_miim_sel = 1'b1; host_opcode = 2'b11;
        @(negedge host_clk);

        // MIIM write frame, with a config read serviced mid-frame
        run_frame(2'b01, 10'h021, 16'hA5A5, 3, lat, fo, ft, nbits);
        check("wr_latency_1281pm1", (lat >= 1280 && lat <= 1282), 1'b1);
        check("wr_bit_count", nbits, 64);
        check("wr_frame_bits", fo, 64'hFFFF_FFFF_1086_A5A5);
        check("wr_frame_tristate", ft, 64'h0);
        check("wr_mdc_period_first", rise_cyc[base + 1] - rise_cyc[base], 20);
        check("wr_mdc_period_last", rise_cyc[base + 63] - rise_cyc[base + 62], 20);
        check("wr_idle_lines", {mdc, mdio_t, mdio_o}, 3'b011);

        // MIIM read frame with the PHY driving 0xBEEF
        phy_word = 16'hBEEF;
        run_frame(2'b11, 10'h021, 16'h0, 0, lat, fo, ft, nbits);
        check("rd_data_at_rdy", host_rd_data, 32'h0000_BEEF);
        check("rd_latency_1281pm1", (lat >= 1280 && lat <= 1282), 1'b1);
        check("rd_header_bits", fo[63:18], {32'hFFFF_FFFF, 14'b00_11_00001_00001});
        check("rd_tristate_ta_data", ft, 64'h3_FFFF);
        repeat (5) @(negedge host_clk);
        check("rd_data_held", host_rd_data, 32'h0000_BEEF);

        // Address frame with a second request pulsed mid-frame
        run_frame(2'b00, 10'h021, 16'h1234, 1, lat, fo, ft, nbits);
        check("addr_frame_bits", fo, 64'hFFFF_FFFF_0086_1234);
        repeat (200) @(negedge host_clk);
        check("second_req_no_extra_frame", total - base, 64);

        // Clearing mdio_en mid-frame: frame completes, rdy stays low
        run_frame(2'b01, 10'h021, 16'h00FF, 2, lat, fo, ft, nbits);
        check("en_clear_frame_bits", fo, 64'hFFFF_FFFF_1086_00FF);
        repeat (50) @(negedge host_clk);
        check("en_clear_rdy_low", host_miim_rdy, 1'b0);
        check("en_clear_no_more_mdc", total - base, 64);

        // Request with mdio_en=0 is ignored
        b0 = total;
        host_miim_sel = 1'b1; host_opcode = 2'b01; host_req = 1'b1;
        @(negedge host_clk);
        host_req = 1'b0; host_opcode = 2'b11;
        repeat (100) @(negedge host_clk);
        check("disabled_req_no_mdc", total - b0, 0);
        check("disabled_rdy_low", {host_miim_rdy, mdc}, 2'b00);

        // Reset in the middle of the DATA field
        cfg_cycle(2'b00, 10'h340, 32'h29);
        base = total;
        host_opcode = 2'b01; host_addr = 10'h021; host_wr_data = 32'hA5A5; host_req = 1'b1;
        @(negedge host_clk);
        host_req = 1'b0; host_opcode = 2'b11;
        n = 0;
        while ((total - base) < 52 && n < 3000) begin
            @(negedge host_clk);
            n++;
        end
        check("reach_data_field_in_bound", (n < 3000), 1'b1);
        host_reset = 1'b1;
        #1;
        check("async_reset_lines", {mdc, mdio_t, mdio_o, host_miim_rdy}, 4'b0110);
        check("async_reset_regs", {host_rd_data, cfg_rx_word1}, 64'h0);
        b0 = total;
        repeat (3) @(negedge host_clk);
        host_reset = 1'b0;
        repeat (50) @(negedge host_clk);
        check("aborted_frame_no_mdc", total - b0, 0);
        check("post_reset_rdy_low", host_miim_rdy, 1'b0);
        cfg_cycle(2'b00, 10'h340, 32'h29);
        check("post_reset_rdy_back", host_miim_rdy, 1'b1);
        run_frame(2'b01, 10'h021, 16'h5A5A, 0, lat, fo, ft, nbits);
        check("post_reset_frame_bits", fo, 64'hFFFF_FFFF_1086_5A5A);
        check("post_reset_bit_count", nbits, 64);
        check("post_reset_latency", (lat >= 1280 && lat <= 1282), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
